memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter.sv | 118 +++++++++++
 tb/tb_memory_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: fetch/data arbiter and sequencer for MemoryInterface; MEMORY_ARBITER_ROUND_ROBIN_EN enables round-robin ties
module memory_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int CLOCK_COUNT_WIDTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CLOCK_COUNT_WIDTH-1:0] waitStates,
    input  logic                         fetchRequest,
    input  logic [ADDRESS_BUS_WIDTH-1:0] fetchAddress,
    output logic [DATA_WIDTH-1:0]        fetchData,
    output logic                         fetchDone,
    input  logic                         dataRequest,
    input  logic [ADDRESS_BUS_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    input  logic                         dataReadWrite,
    input  logic                         dataIsMemory,
    output logic [DATA_WIDTH-1:0]        dataOut,
    output logic                         dataDone,
    output logic [ADDRESS_BUS_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0]        memDataOut,
    input  logic [DATA_WIDTH-1:0]        memDataIn,
    output logic                         memReadWrite,
    output logic                         memIsMemory,
    output logic                         memEnable,
    output logic                         memReset,
    input  logic                         memReady,
    output logic [CLOCK_COUNT_WIDTH-1:0] memClockCount,
    output logic                         busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT_RDY, DONE} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, fetch_data_q, fetch_data_d, data_out_q, data_out_d;
    logic rw_q, rw_d, is_mem_q, is_mem_d;
    logic grant_data;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign grant_data = dataRequest && !(fetchRequest && last_q);
`else
    assign grant_data = dataRequest;
`endif
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        is_mem_d     = is_mem_q;
        fetch_data_d = fetch_data_q;
        data_out_d   = data_out_q;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: if (fetchRequest || dataRequest) begin
                state_d  = ISSUE;
                owner_d  = grant_data;
                addr_d   = grant_data ? dataAddress : fetchAddress;
                wdata_d  = grant_data ? dataIn : '0;
                rw_d     = grant_data ? dataReadWrite : 1'b1;
                is_mem_d = grant_data ? dataIsMemory : 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                last_d   = grant_data;
`endif
            end
            ISSUE:  state_d = SETTLE;
            SETTLE: state_d = WAIT_RDY;
            WAIT_RDY: if (memReady) begin
                state_d      = DONE;
                fetch_data_d = owner_q ? fetch_data_q : memDataIn;
                data_out_d   = owner_q ? memDataIn : data_out_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            is_mem_q     <= 1'b0;
            fetch_data_q <= '0;
            data_out_q   <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            is_mem_q     <= is_mem_d;
            fetch_data_q <= fetch_data_d;
            data_out_q   <= data_out_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end
    assign memAddress    = addr_q;
    assign memDataOut    = wdata_q;
    assign memReadWrite  = rw_q;
    assign memIsMemory   = is_mem_q;
    assign memEnable     = state_q == ISSUE;
    assign memReset      = reset;
    assign memClockCount = waitStates;
    assign busy          = state_q != IDLE;
    assign fetchDone     = state_q == DONE && !owner_q;
    assign dataDone      = state_q == DONE && owner_q;
    assign fetchData     = fetch_data_q;
    assign dataOut       = data_out_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed table plus corner sequences against a small memory model
module tb_memory_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] wait_states;
    logic fetch_req, data_req, data_rw, data_is_mem;
    logic [31:0] fetch_addr, data_addr, data_in;
    logic [31:0] fetch_data, data_out, mem_addr, mem_dout, mem_din;
    logic fetch_done, data_done, mem_rw, mem_is_mem, mem_en, mem_rst, mem_ready, busy;
    logic [2:0] mem_cc;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    memory_arbiter dut (
        .clock(clk), .reset(rst), .waitStates(wait_states),
        .fetchRequest(fetch_req), .fetchAddress(fetch_addr), .fetchData(fetch_data), .fetchDone(fetch_done),
        .dataRequest(data_req), .dataAddress(data_addr), .dataIn(data_in), .dataReadWrite(data_rw),
        .dataIsMemory(data_is_mem), .dataOut(data_out), .dataDone(data_done),
        .memAddress(mem_addr), .memDataOut(mem_dout), .memDataIn(mem_din), .memReadWrite(mem_rw),
        .memIsMemory(mem_is_mem), .memEnable(mem_en), .memReset(mem_rst), .memReady(mem_ready),
        .memClockCount(mem_cc), .busy(busy)
    );
    logic [31:0] mem [16];
    logic [31:0] rdata;
    int cnt;
    int delay;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) rdata <= mem[mem_addr[5:2]];
            else begin
                mem[mem_addr[5:2]] <= mem_dout;
                rdata <= mem_dout;
            end
            cnt <= delay;
        end else if (cnt != 0) cnt <= cnt - 1;
    end
    assign mem_ready = cnt == 0;
    assign mem_din = rdata;
    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        is_mem;
        int          dly;
        logic [31:0] word;
        int          lat;
    } vec_t;
    vec_t tbl [6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic idle_inputs();
        fetch_req = 1'b0; data_req = 1'b0;
        fetch_addr = 32'h0; data_addr = 32'h0; data_in = 32'h0;
        data_rw = 1'b1; data_is_mem = 1'b1;
    endtask
    task automatic txn(input vec_t v);
        int en;
        int lat;
        logic got;
        logic wrong;
        en = 0; lat = 0; got = 1'b0; wrong = 1'b0;
        @(negedge clk);
        delay = v.dly;
        if (v.is_data) begin
            data_req = 1'b1; data_addr = v.addr; data_in = v.wdata;
            data_rw = v.rw; data_is_mem = v.is_mem;
        end else begin
            fetch_req = 1'b1; fetch_addr = v.addr;
        end
        for (int c = 1; c <= 30 && !got; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin
                en++;
                chk("mem_addr", mem_addr, v.addr);
                chk("mem_rw", 32'(mem_rw), 32'(v.rw));
                chk("mem_is_mem", 32'(mem_is_mem), 32'(v.is_mem));
                chk("mem_dout", mem_dout, v.is_data ? v.wdata : 32'h0);
                data_addr = 32'hbad0; fetch_addr = 32'hbad4; data_in = 32'hbad8;
            end
            if (v.is_data ? fetch_done : data_done) wrong = 1'b1;
            if (v.is_data ? data_done : fetch_done) begin
                got = 1'b1;
                lat = c;
                chk("word", v.is_data ? data_out : fetch_data, v.word);
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", 32'(lat), 32'(v.lat));
        chk("enable_count", 32'(en), 32'd1);
        chk("other_done", 32'(wrong), 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(fetch_done | data_done), 32'd0);
    endtask
    initial begin
        logic g [4];
        int ng;
        int en;
        int nd;
        logic early;
        for (int i = 0; i < 16; i++) mem[i] = 32'(2 * i);
        cnt = 0; rdata = 32'h0; delay = 1;
        tbl[0] = '{1'b0, 32'h4,  32'h0,    1'b1, 1'b1, 1, 32'h2,    4};
        tbl[1] = '{1'b1, 32'h0,  32'h1,    1'b0, 1'b1, 0, 32'h1,    4};
        tbl[2] = '{1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 2, 32'h1,    5};
        tbl[3] = '{1'b1, 32'h8,  32'h0,    1'b1, 1'b1, 3, 32'h4,    6};
        tbl[4] = '{1'b1, 32'h3c, 32'hdead, 1'b0, 1'b0, 1, 32'hdead, 4};
        tbl[5] = '{1'b0, 32'h3c, 32'h0,    1'b1, 1'b1, 0, 32'hdead, 4};
        idle_inputs();
        wait_states = 3'd5;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_reset", 32'(mem_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_enable", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_fetch_data", fetch_data, 32'h0);
        chk("rst_dones", 32'(fetch_done | data_done), 32'd0);
        chk("clock_count", 32'(mem_cc), 32'd5);
        rst = 1'b0;
        #1;
        chk("mem_reset_low", 32'(mem_rst), 32'd0);
        for (int i = 0; i < 6; i++) txn(tbl[i]);
        // data request dropped while waiting for ready
        @(negedge clk);
        delay = 3;
        data_req = 1'b1; data_addr = 32'h8; data_rw = 1'b1; data_is_mem = 1'b1;
        en = 0; nd = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (c == 2) data_req = 1'b0;
            if (mem_en) en++;
            if (data_done) begin
                nd++;
                chk("drop_word", data_out, 32'h4);
            end
        end
        chk("drop_enable_count", 32'(en), 32'd1);
        chk("drop_done_count", 32'(nd), 32'd1);
        // reset during WAIT
        @(negedge clk);
        delay = 5;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("in_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("wrst_busy", 32'(busy), 32'd0);
        chk("wrst_enable", 32'(mem_en), 32'd0);
        chk("wrst_mem_addr", mem_addr, 32'h0);
        chk("wrst_mem_dout", mem_dout, 32'h0);
        chk("wrst_mem_rw", 32'(mem_rw), 32'd0);
        chk("wrst_mem_is_mem", 32'(mem_is_mem), 32'd0);
        chk("wrst_fetch_data", fetch_data, 32'h0);
        chk("wrst_data_out", data_out, 32'h0);
        chk("wrst_mem_reset", 32'(mem_rst), 32'd1);
        rst = 1'b0;
        fetch_req = 1'b0;
        early = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (fetch_done | data_done | mem_en) early = 1'b1;
        end
        chk("aborted_no_done", 32'(early), 32'd0);
        txn(tbl[0]);
        // both requesters held across several grants
        @(negedge clk);
        delay = 0;
        fetch_req = 1'b1; fetch_addr = 32'h4;
        data_req = 1'b1; data_addr = 32'h8; data_rw = 1'b1; data_is_mem = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(posedge clk); #1;
            if (fetch_done) begin
                chk("arb_fetch_word", fetch_data, 32'h2);
                g[ng] = 1'b0; ng++;
            end else if (data_done) begin
                chk("arb_data_word", data_out, 32'h4);
                g[ng] = 1'b1; ng++;
            end
        end
        chk("arb_grants", 32'(ng), 32'd4);
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        chk("arb_order", {28'h0, g[0], g[1], g[2], g[3]}, 32'ha);
`else
        chk("arb_order", {28'h0, g[0], g[1], g[2], g[3]}, 32'hf);
`endif
        idle_inputs();
        repeat (6) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
